mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage that consumes EX/MEM register outputs (alu_out_M as address, rt_data_M as store data, instr_M opcode, mem_rd_M/mem_wr_M).
- Drives the SRAM-like data bus with a req/addr_ok/data_ok handshake and stalls the pipeline while an access is outstanding.
- Detects misaligned addresses and formats load data (byte/half select, sign/zero extend) for the MEM/WB register.

Parameters:
- ADDR_W, 32, width of data bus address and bad_vaddr.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_M  in  32  instruction in M; opcode = [31:26]
- alu_out_M  in  32  effective address
- rt_data_M  in  32  store data
- mem_rd_M, mem_wr_M  in  1 each  load / store in M
- exc_pending_M  in  1  other exception on this instr (overflow, break, syscall, ri, eret); suppresses access
- flush_M  in  1  squash instruction in M
- hold_M  in  1  stall of M from sources other than this block
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  ADDR_W  bus address (= alu_out_M)
- data_wdata  out  32  replicated store data
- data_wstrb  out  4  byte enables (0 for loads)
- data_addr_ok, data_data_ok  in  1 each  bus handshakes
- data_rdata  in  32  bus read data
- mem_stall_M  out  1  to hazard unit; stalls F..M
- rdata_M  out  32  formatted load result
- adel_M, ades_M  out  1 each  load / store address error
- bad_vaddr_M  out  ADDR_W  faulting address

Behaviour:
- Opcodes: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, SB 101000, SH 101001, SW 101011.
- misalign = half op & addr[0], or word op & addr[1:0]≠0.
- adel_M = mem_rd_M & misalign; ades_M = mem_wr_M & misalign. Both combinational.
- bad_vaddr_M = alu_out_M when adel_M|ades_M, else 0.
- access_valid = (mem_rd_M|mem_wr_M) & ~misalign & ~exc_pending_M & ~flush_M.
- States:
  - IDLE: data_req = access_valid (combinational).
    - access_valid & addr_ok → WAIT_DATA.
    - access_valid & ~addr_ok → REQ.
  - REQ: data_req = 1; address and controls held stable.
    - addr_ok → WAIT_DATA.
    - flush_M (before addr_ok) → IDLE, request withdrawn.
  - WAIT_DATA: data_req = 0.
    - data_ok & ~hold_M → IDLE.
    - data_ok & hold_M → HOLD.
    - flush_M & ~data_ok → DRAIN.
    - Same cycle flush_M & data_ok → IDLE, data discarded.
  - HOLD: access complete, instruction still held in M. No reissue; rdata_M comes from the capture register.
    - ~hold_M | flush_M → IDLE.
  - DRAIN: wait for the orphaned data_ok; data_req = 0; data discarded.
    - data_ok → IDLE.
- mem_stall_M = 1 when:
  - (IDLE|REQ) & access_valid, or
  - WAIT_DATA & ~data_ok, or
  - DRAIN & (mem_rd_M|mem_wr_M).
  - It is 0 in the data_ok cycle, so the pipeline advances in the completion cycle. Latency with a zero-wait bus is 2 cycles in M.
- Loads: shift = addr[1:0]×8 for bytes, addr[1]×16 for halves. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rdata_M is formatted data_rdata in the data_ok cycle, and the captured register value in HOLD.
  - The capture register loads the formatted value on every accepted data_ok.
- Stores:
  - SB: wdata = {4{b}}; wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}; wstrb = addr[1] ? 1100 : 0011.
  - SW: wstrb = 1111.
- Reset (async): state IDLE, capture register 0. All outputs therefore 0: data_req, mem_stall_M, rdata_M. Reset mid-transaction abandons it; the bus is reset by the same rst.
- No second request may be issued while in WAIT_DATA, HOLD or DRAIN (single outstanding transaction).

Decomposition:
- Shared package mips_defs_pkg holds:
  - opcode constants (OP_LB..OP_SW)
  - data_size encodings (SIZE_B/H/W)
  - state enum mem_state_t {IDLE, REQ, WAIT_DATA, HOLD, DRAIN}
- One natural sub-module: mem_data_align, purely combinational. It produces wdata/wstrb and formats load data from opcode, addr[1:0] and raw data. It is reused by the future cache path.

Test Plan:
- LW to 0x100, addr_ok and data_ok 1 cycle later, rdata 0xDEADBEEF:
  - data_req 1 in cycle 0; mem_stall_M 1 then 0.
  - rdata_M = 0xDEADBEEF on completion.
- LB at 0x103 with rdata 0x80FF_0000, then LBU at 0x103 with the same data:
  - LB: rdata_M = 0xFFFFFF80. LBU: rdata_M = 0x00000080.
- SH at 0x202, rt = 0x1234ABCD:
  - wdata = 0xABCDABCD, wstrb = 1100, size = 1.
  - LW at 0x202: adel_M = 1, bad_vaddr_M = 0x202, no data_req.
- addr_ok delayed 3 cycles:
  - data_req held with stable addr, mem_stall_M 1 throughout.
  - hold_M = 1 at data_ok → HOLD, rdata_M held.
  - After hold_M drops, returns to IDLE with no reissue.
- flush_M in WAIT_DATA, next instr LW in M:
  - DRAIN; no data_req until the old data_ok arrives; stale data not seen on rdata_M.
  - New request is issued the cycle after.
- rst asserted asynchronously in REQ:
  - data_req and mem_stall_M drop immediately, state IDLE, rdata_M = 0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs_pkg
// Description : Shared definitions for the MIPS memory-access path: load and
//               store opcodes, bus transfer-size encodings, the memory-stage
//               FSM state type and an opcode-to-size helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs_pkg;

    // Load / store opcodes (instr[31:26])
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // data_size encodings on the bus
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Memory-stage bus FSM
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        HOLD      = 3'd3,
        DRAIN     = 3'd4
    } mem_state_t;

    // Transfer size implied by an opcode. Non-memory opcodes report a word so
    // that only genuine byte/half accesses relax the alignment check.
    function automatic logic [1:0] op_size(input logic [5:0] op);
        logic [1:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SIZE_B;
            OP_LH, OP_LHU, OP_SH: sz = SIZE_H;
            default:              sz = SIZE_W;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_align
// Description : Purely combinational data alignment for the memory path.
//               Produces store byte lanes / strobes and formats raw load data
//               (byte/half select with sign or zero extension).
// Ports       : op         in  6   opcode
//               addr_lo    in  2   address bits [1:0]
//               store_data in  32  register store data
//               load_raw   in  32  raw bus read data
//               size       out 2   transfer size (SIZE_B/H/W)
//               misalign   out 1   address not naturally aligned for size
//               wdata      out 32  store data replicated onto all lanes
//               wstrb      out 4   byte enables (zero for non-stores)
//               load_data  out 32  formatted load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_align
    import mips_defs_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [1:0]  size,
    output logic        misalign,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign size     = op_size(op);
    assign misalign = ((size == SIZE_H) && addr_lo[0]) ||
                      ((size == SIZE_W) && (addr_lo != 2'b00));

    // Selected lane is moved down to bit 0 before extension
    assign w_byte_shift = load_raw >> {addr_lo, 3'b000};
    assign w_half_shift = load_raw >> {addr_lo[1], 4'b0000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_half       = w_half_shift[15:0];

    always_comb begin
        wdata = store_data;
        wstrb = 4'b0000;
        case (op)
            OP_SB: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            OP_SH: begin
                wdata = {2{store_data[15:0]}};
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b0000;
            end
        endcase
    end

    always_comb begin
        load_data = load_raw;
        case (op)
            OP_LB:   load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  load_data = {24'h000000, w_byte};
            OP_LH:   load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  load_data = {16'h0000, w_half};
            default: load_data = load_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MIPS memory stage. Issues a single outstanding access on an
//               SRAM-like bus (req/addr_ok/data_ok), stalls the pipeline while
//               the access is in flight, flags misaligned addresses and
//               formats load data for the MEM/WB register.
// Ports       : clk, rst                      clock, async active-high reset
//               instr_M, alu_out_M, rt_data_M instruction, address, store data
//               mem_rd_M, mem_wr_M            load / store in M
//               exc_pending_M, flush_M        suppress / squash the access
//               hold_M                        external stall of M
//               data_*                        bus request / response
//               mem_stall_M                   stall to hazard unit
//               rdata_M                       formatted load result
//               adel_M, ades_M, bad_vaddr_M   address-error reporting
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mips_defs_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_M,
    input  logic [31:0]       alu_out_M,
    input  logic [31:0]       rt_data_M,
    input  logic              mem_rd_M,
    input  logic              mem_wr_M,
    input  logic              exc_pending_M,
    input  logic              flush_M,
    input  logic              hold_M,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              mem_stall_M,
    output logic [31:0]       rdata_M,
    output logic              adel_M,
    output logic              ades_M,
    output logic [ADDR_W-1:0] bad_vaddr_M
);

    mem_state_t  r_state;
    mem_state_t  w_state_nxt;
    logic [31:0] r_capture;

    logic [1:0]  w_size;
    logic        w_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_fmt;
    logic        w_mem_op;
    logic        w_access_valid;
    logic        w_req;
    logic        w_stall;
    logic        w_capture;
    logic        w_unused_instr;

    // Only the opcode field matters here
    assign w_unused_instr = ^instr_M[25:0];

    mem_data_align u_align (
        .op         (instr_M[31:26]),
        .addr_lo    (alu_out_M[1:0]),
        .store_data (rt_data_M),
        .load_raw   (data_rdata),
        .size       (w_size),
        .misalign   (w_misalign),
        .wdata      (data_wdata),
        .wstrb      (w_wstrb),
        .load_data  (w_load_fmt)
    );

    assign w_mem_op       = mem_rd_M | mem_wr_M;
    assign w_access_valid = w_mem_op & ~w_misalign & ~exc_pending_M & ~flush_M;

    assign adel_M      = mem_rd_M & w_misalign;
    assign ades_M      = mem_wr_M & w_misalign;
    assign bad_vaddr_M = (adel_M | ades_M) ? ADDR_W'(alu_out_M) : '0;

    // Address/controls come straight from EX/MEM; the stall keeps them stable
    // for as long as the request is pending.
    assign data_addr  = ADDR_W'(alu_out_M);
    assign data_wr    = mem_wr_M;
    assign data_size  = w_size;
    assign data_wstrb = mem_wr_M ? w_wstrb : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_req   = w_access_valid;
                w_stall = w_access_valid;
                if (w_access_valid) begin
                    w_state_nxt = data_addr_ok ? WAIT_DATA : REQ;
                end
            end
            REQ: begin
                w_req   = 1'b1;
                w_stall = w_access_valid;
                // If the bus accepts in the same cycle as a flush, the
                // transaction exists and its data must be drained.
                if (data_addr_ok) begin
                    w_state_nxt = flush_M ? DRAIN : WAIT_DATA;
                end else if (flush_M) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DATA: begin
                w_stall = ~data_data_ok;
                if (data_data_ok) begin
                    w_capture   = ~flush_M;
                    w_state_nxt = (hold_M && !flush_M) ? HOLD : IDLE;
                end else if (flush_M) begin
                    w_state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (!hold_M || flush_M) begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                w_stall = w_mem_op;
                if (data_data_ok) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs forced low while reset is asserted so the bus and hazard unit
    // see the abandonment immediately, not at the next edge.
    assign data_req    = w_req & ~rst;
    assign mem_stall_M = w_stall & ~rst;

    // Completion cycle forwards the bus data directly; otherwise the capture
    // register (held value in HOLD, zero after reset).
    assign rdata_M = w_capture ? w_load_fmt : r_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_capture <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_capture <= w_load_fmt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Directed scenarios
//               plus a randomized load/store sequence against a behavioural
//               model of alignment, formatting and handshake timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam logic [5:0] C_LB  = 6'b100000;
    localparam logic [5:0] C_LH  = 6'b100001;
    localparam logic [5:0] C_LW  = 6'b100011;
    localparam logic [5:0] C_LBU = 6'b100100;
    localparam logic [5:0] C_LHU = 6'b100101;
    localparam logic [5:0] C_SB  = 6'b101000;
    localparam logic [5:0] C_SH  = 6'b101001;
    localparam logic [5:0] C_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_M = '0;
    logic [31:0] alu_out_M = '0;
    logic [31:0] rt_data_M = '0;
    logic        mem_rd_M = 1'b0;
    logic        mem_wr_M = 1'b0;
    logic        exc_pending_M = 1'b0;
    logic        flush_M = 1'b0;
    logic        hold_M = 1'b0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        mem_stall_M;
    logic [31:0] rdata_M;
    logic        adel_M;
    logic        ades_M;
    logic [31:0] bad_vaddr_M;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_load = '0;   // value the last completed load left behind

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_M       (instr_M),
        .alu_out_M     (alu_out_M),
        .rt_data_M     (rt_data_M),
        .mem_rd_M      (mem_rd_M),
        .mem_wr_M      (mem_wr_M),
        .exc_pending_M (exc_pending_M),
        .flush_M       (flush_M),
        .hold_M        (hold_M),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_wstrb    (data_wstrb),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .mem_stall_M   (mem_stall_M),
        .rdata_M       (rdata_M),
        .adel_M        (adel_M),
        .ades_M        (ades_M),
        .bad_vaddr_M   (bad_vaddr_M)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [5:0] op);
        if (op == C_LB || op == C_LBU || op == C_SB) return 0;
        if (op == C_LH || op == C_LHU || op == C_SH) return 1;
        return 2;
    endfunction

    function automatic bit ref_misalign(input logic [5:0] op, input logic [31:0] a);
        int s = ref_size(op);
        return (s == 1 && (a % 2) != 0) || (s == 2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v;
        int s = ref_size(op);
        if (s == 0) begin
            v = (raw >> (8 * (a % 4))) & 32'hFF;
            if (op == C_LB && v >= 128) v = v | 32'hFFFFFF00;
        end else if (s == 1) begin
            v = (raw >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (op == C_LH && v >= 32768) v = v | 32'hFFFF0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] rt);
        int s = ref_size(op);
        if (s == 0) return (rt & 32'hFF) * 32'h01010101;
        if (s == 1) return (rt & 32'hFFFF) * 32'h00010001;
        return rt;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [5:0] op, input logic [31:0] a);
        int s = ref_size(op);
        if (s == 0) return 4'(1 << (a % 4));
        if (s == 1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic bit is_load(input logic [5:0] op);
        return op == C_LB || op == C_LBU || op == C_LH || op == C_LHU || op == C_LW;
    endfunction

    task automatic idle_inputs();
        mem_rd_M = 0; mem_wr_M = 0; flush_M = 0; hold_M = 0; exc_pending_M = 0;
        data_addr_ok = 0; data_data_ok = 0; instr_M = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; instr_M = {C_LW, 26'h0}; alu_out_M = 32'h100; mem_rd_M = 1;
        #1;
        total++; if (data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", data_req); end
        total++; if (mem_stall_M !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", mem_stall_M); end
        total++; if (rdata_M !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_M); end
        @(negedge clk); rst = 0; idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_lw_basic();
        instr_M = {C_LW, 26'h12345}; alu_out_M = 32'h100; mem_rd_M = 1; data_addr_ok = 1;
        #1;
        total++; if (data_req !== 1'b1) begin bad++; $display("FAIL lw_req got=%b exp=1", data_req); end
        total++; if (mem_stall_M !== 1'b1) begin bad++; $display("FAIL lw_stall0 got=%b exp=1", mem_stall_M); end
        total++; if (data_addr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=100", data_addr); end
        total++; if (data_size !== 2'd2 || data_wr !== 1'b0 || data_wstrb !== 4'b0)
            begin bad++; $display("FAIL lw_ctrl got=%0d/%b/%b exp=2/0/0000", data_size, data_wr, data_wstrb); end
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEADBEEF;
        #1;
        total++; if (data_req !== 1'b0) begin bad++; $display("FAIL lw_req1 got=%b exp=0", data_req); end
        total++; if (mem_stall_M !== 1'b0) begin bad++; $display("FAIL lw_stall1 got=%b exp=0", mem_stall_M); end
        total++; if (rdata_M !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata_M); end
        @(negedge clk); last_load = 32'hDEADBEEF; idle_inputs(); data_rdata = 32'h0;
        #1;
        total++; if (rdata_M !== last_load) begin bad++; $display("FAIL lw_capture got=%h exp=%h", rdata_M, last_load); end
        @(negedge clk);
    endtask

    task automatic test_lb_lbu();
        logic [5:0] ops [2];
        logic [31:0] exp_v;
        ops[0] = C_LB; ops[1] = C_LBU;
        for (int i = 0; i < 2; i++) begin
            instr_M = {ops[i], 26'h0}; alu_out_M = 32'h103; mem_rd_M = 1; data_addr_ok = 1;
            #1;
            total++; if (data_req !== 1'b1 || data_size !== 2'd0)
                begin bad++; $display("FAIL lb_req[%0d] got=%b/%0d exp=1/0", i, data_req, data_size); end
            @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80FF0000;
            exp_v = ref_load(ops[i], 32'h103, 32'h80FF0000);
            #1;
            total++; if (rdata_M !== exp_v) begin bad++; $display("FAIL lb_rdata[%0d] got=%h exp=%h", i, rdata_M, exp_v); end
            @(negedge clk); last_load = exp_v; data_data_ok = 0; mem_rd_M = 0;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_sh_misaligned();
        instr_M = {C_SH, 26'h0}; alu_out_M = 32'h202; rt_data_M = 32'h1234ABCD; mem_wr_M = 1; data_addr_ok = 1;
        #1;
        total++; if (data_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", data_wdata); end
        total++; if (data_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got=%b exp=1100", data_wstrb); end
        total++; if (data_size !== 2'd1 || data_wr !== 1'b1 || data_req !== 1'b1)
            begin bad++; $display("FAIL sh_ctrl got=%0d/%b/%b exp=1/1/1", data_size, data_wr, data_req); end
        total++; if (ades_M !== 1'b0) begin bad++; $display("FAIL sh_ades got=%b exp=0", ades_M); end
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1;
        #1;
        total++; if (mem_stall_M !== 1'b0) begin bad++; $display("FAIL sh_stall got=%b exp=0", mem_stall_M); end
        @(negedge clk); data_data_ok = 0; mem_wr_M = 0;
        instr_M = {C_LW, 26'h0}; alu_out_M = 32'h202; mem_rd_M = 1;
        #1;
        total++; if (adel_M !== 1'b1 || ades_M !== 1'b0) begin bad++; $display("FAIL mis_adel got=%b/%b exp=1/0", adel_M, ades_M); end
        total++; if (bad_vaddr_M !== 32'h202) begin bad++; $display("FAIL mis_badva got=%h exp=202", bad_vaddr_M); end
        total++; if (data_req !== 1'b0 || mem_stall_M !== 1'b0)
            begin bad++; $display("FAIL mis_req got=%b/%b exp=0/0", data_req, mem_stall_M); end
        @(negedge clk); idle_inputs();
        #1;
        total++; if (bad_vaddr_M !== 32'h0 || adel_M !== 1'b0) begin bad++; $display("FAIL mis_clear got=%h/%b exp=0/0", bad_vaddr_M, adel_M); end
        @(negedge clk);
    endtask

    task automatic test_addr_delay_hold();
        instr_M = {C_LW, 26'h0}; alu_out_M = 32'h340; mem_rd_M = 1; data_addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            #1;
            total++; if (data_req !== 1'b1 || data_addr !== 32'h340 || mem_stall_M !== 1'b1)
                begin bad++; $display("FAIL dly_req[%0d] got=%b/%h/%b exp=1/340/1", i, data_req, data_addr, mem_stall_M); end
            @(negedge clk);
        end
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BADF00D; hold_M = 1;
        #1;
        total++; if (mem_stall_M !== 1'b0 || rdata_M !== 32'h0BADF00D)
            begin bad++; $display("FAIL hold_done got=%b/%h exp=0/0badf00d", mem_stall_M, rdata_M); end
        @(negedge clk); data_data_ok = 0; data_rdata = 32'hFFFFFFFF; last_load = 32'h0BADF00D;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (rdata_M !== last_load || data_req !== 1'b0)
                begin bad++; $display("FAIL hold_keep[%0d] got=%h/%b exp=%h/0", i, rdata_M, data_req, last_load); end
            @(negedge clk);
        end
        hold_M = 0;
        #1;
        total++; if (data_req !== 1'b0 || rdata_M !== last_load)
            begin bad++; $display("FAIL hold_exit got=%b/%h exp=0/%h", data_req, rdata_M, last_load); end
        @(negedge clk); idle_inputs();
        #1;
        total++; if (data_req !== 1'b0 || mem_stall_M !== 1'b0)
            begin bad++; $display("FAIL hold_noreissue got=%b/%b exp=0/0", data_req, mem_stall_M); end
        @(negedge clk);
    endtask

    task automatic test_flush_drain();
        logic [31:0] raw2;
        logic [31:0] exp_v;
        // establish a known capture value with a completed load
        instr_M = {C_LW, 26'h0}; alu_out_M = 32'h400; mem_rd_M = 1; data_addr_ok = 1;
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h13572468;
        @(negedge clk); data_data_ok = 0; last_load = 32'h13572468;
        // load A is accepted, then squashed while its data is outstanding
        alu_out_M = 32'h500; data_addr_ok = 1;
        #1;
        total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fl_reqA got=%b exp=1", data_req); end
        @(negedge clk); data_addr_ok = 0; flush_M = 1;
        #1;
        total++; if (data_req !== 1'b0) begin bad++; $display("FAIL fl_wait_req got=%b exp=0", data_req); end
        @(negedge clk); flush_M = 0; instr_M = {C_LH, 26'h0}; alu_out_M = 32'h600; mem_rd_M = 1;
        #1;
        total++; if (data_req !== 1'b0 || mem_stall_M !== 1'b1)
            begin bad++; $display("FAIL fl_drain got=%b/%b exp=0/1", data_req, mem_stall_M); end
        @(negedge clk); data_data_ok = 1; data_rdata = 32'h5555AAAA;
        #1;
        total++; if (data_req !== 1'b0 || rdata_M !== last_load)
            begin bad++; $display("FAIL fl_stale got=%b/%h exp=0/%h", data_req, rdata_M, last_load); end
        @(negedge clk); data_data_ok = 0; data_addr_ok = 1; data_rdata = 32'h0;
        #1;
        total++; if (data_req !== 1'b1 || data_addr !== 32'h600 || data_size !== 2'd1)
            begin bad++; $display("FAIL fl_reqB got=%b/%h/%0d exp=1/600/1", data_req, data_addr, data_size); end
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1;
        raw2 = $urandom | 32'h1; data_rdata = raw2;
        exp_v = ref_load(C_LH, 32'h600, raw2);
        #1;
        total++; if (rdata_M !== exp_v || mem_stall_M !== 1'b0)
            begin bad++; $display("FAIL fl_dataB got=%h/%b exp=%h/0", rdata_M, mem_stall_M, exp_v); end
        @(negedge clk); last_load = exp_v; idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        // put a nonzero value in the capture register first
        instr_M = {C_LW, 26'h0}; alu_out_M = 32'h680; mem_rd_M = 1; data_addr_ok = 1;
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE0001;
        @(negedge clk); data_data_ok = 0; last_load = 32'hCAFE0001;
        alu_out_M = 32'h700;
        #1;
        total++; if (data_req !== 1'b1) begin bad++; $display("FAIL ar_req0 got=%b exp=1", data_req); end
        @(negedge clk);
        #1;
        total++; if (data_req !== 1'b1 || mem_stall_M !== 1'b1)
            begin bad++; $display("FAIL ar_inreq got=%b/%b exp=1/1", data_req, mem_stall_M); end
        #1; rst = 1;
        #1;
        total++; if (data_req !== 1'b0 || mem_stall_M !== 1'b0 || rdata_M !== 32'h0)
            begin bad++; $display("FAIL ar_drop got=%b/%b/%h exp=0/0/0", data_req, mem_stall_M, rdata_M); end
        @(negedge clk); rst = 0; idle_inputs();
        #1;
        total++; if (rdata_M !== 32'h0 || data_req !== 1'b0)
            begin bad++; $display("FAIL ar_after got=%h/%b exp=0/0", rdata_M, data_req); end
        last_load = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [31:0] addr, rt, raw, exp_v;
        int adly, ddly;
        bit ld, mis, exc;
        ops[0] = C_LB; ops[1] = C_LBU; ops[2] = C_LH; ops[3] = C_LHU;
        ops[4] = C_LW; ops[5] = C_SB;  ops[6] = C_SH; ops[7] = C_SW;
        for (int n = 0; n < 60; n++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = {16'h0001, 14'($urandom), 2'b00};
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom);
            rt   = $urandom; raw = $urandom;
            adly = $urandom_range(0, 2); ddly = $urandom_range(1, 3);
            exc  = ($urandom_range(0, 9) == 0);
            ld   = is_load(op);
            mis  = ref_misalign(op, addr);
            instr_M = {op, 26'($urandom)}; alu_out_M = addr; rt_data_M = rt;
            mem_rd_M = ld; mem_wr_M = !ld; exc_pending_M = exc; data_addr_ok = 0;
            #1;
            total++; if (adel_M !== (ld && mis) || ades_M !== (!ld && mis) || bad_vaddr_M !== (mis ? addr : 32'h0))
                begin bad++; $display("FAIL rnd_exc[%0d] got=%b/%b/%h exp=%b/%b/%h", n, adel_M, ades_M, bad_vaddr_M, ld && mis, !ld && mis, mis ? addr : 32'h0); end
            if (mis || exc) begin
                total++; if (data_req !== 1'b0 || mem_stall_M !== 1'b0)
                    begin bad++; $display("FAIL rnd_suppress[%0d] got=%b/%b exp=0/0", n, data_req, mem_stall_M); end
                @(negedge clk);
            end else begin
                for (int c = 0; c <= adly; c++) begin
                    data_addr_ok = (c == adly);
                    #1;
                    total++; if (data_req !== 1'b1 || mem_stall_M !== 1'b1 || data_addr !== addr || data_wr !== !ld || data_size !== 2'(ref_size(op)))
                        begin bad++; $display("FAIL rnd_req[%0d.%0d] got=%b/%b/%h/%b/%0d exp=1/1/%h/%b/%0d", n, c, data_req, mem_stall_M, data_addr, data_wr, data_size, addr, !ld, ref_size(op)); end
                    total++; if (data_wstrb !== (ld ? 4'b0000 : ref_wstrb(op, addr)) || (!ld && data_wdata !== ref_wdata(op, rt)))
                        begin bad++; $display("FAIL rnd_wr[%0d.%0d] got=%b/%h exp=%b/%h", n, c, data_wstrb, data_wdata, ld ? 4'b0000 : ref_wstrb(op, addr), ref_wdata(op, rt)); end
                    @(negedge clk);
                end
                data_addr_ok = 0;
                for (int c = 1; c <= ddly; c++) begin
                    data_data_ok = (c == ddly);
                    data_rdata   = (c == ddly) ? raw : $urandom;
                    #1;
                    total++; if (data_req !== 1'b0 || mem_stall_M !== (c != ddly))
                        begin bad++; $display("FAIL rnd_wait[%0d.%0d] got=%b/%b exp=0/%b", n, c, data_req, mem_stall_M, c != ddly); end
                    if (c == ddly && ld) begin
                        exp_v = ref_load(op, addr, raw);
                        total++; if (rdata_M !== exp_v)
                            begin bad++; $display("FAIL rnd_rdata[%0d] op=%b addr=%h got=%h exp=%h", n, op, addr, rdata_M, exp_v); end
                        last_load = exp_v;
                    end
                    @(negedge clk);
                end
                data_data_ok = 0;
            end
            exc_pending_M = 0;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_lw_basic();
        test_lb_lbu();
        test_sh_misaligned();
        test_addr_delay_hold();
        test_flush_drain();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
